// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, funct codes, ALU encodings, decode records.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } aluOpT;

  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
    logic branchEq;
    logic branchNe;
    logic jump;
    logic jr;
    logic useImm;
  } ctrlT;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic        valid;
    aluOpT       aluOp;
    ctrlT        ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] target;
    logic [31:0] instrAddr;
  } exRegT;

  function automatic logic [31:0] signExt16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake, including the branch/jump redirect.
interface decode_stage_if;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrAddr;
  logic        InstrReady;
  logic        Flush;

  modport master (output InstrValid, Instr, InstrAddr, Flush, input InstrReady);
  modport slave  (input InstrValid, Instr, InstrAddr, Flush, output InstrReady);
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: controls, destination, immediate.
module instr_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrlT        ctrl,
  output aluOpT       aluOp,
  output logic [31:0] imm,
  output logic [4:0]  dest,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        readsRt,
  output logic        isJal,
  output logic        illegal
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm16 = instr[15:0];

  // Opcode/funct decode; unsupported encodings collapse to an inert bubble.
  always_comb begin
    ctrl    = '0;
    aluOp   = ALU_ADD;
    imm     = '0;
    dest    = '0;
    readsRt = 1'b0;
    isJal   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        readsRt       = 1'b1;
        dest          = rd;
        ctrl.regWrite = 1'b1;
        case (funct)
          FN_ADD: aluOp = ALU_ADD;
          FN_SUB: aluOp = ALU_SUB;
          FN_AND: aluOp = ALU_AND;
          FN_OR:  aluOp = ALU_OR;
          FN_SLT: aluOp = ALU_SLT;
          FN_SLL: begin
            aluOp       = ALU_SLL;
            ctrl.useImm = 1'b1;
            imm         = {27'd0, shamt};
          end
          FN_SRL: begin
            aluOp       = ALU_SRL;
            ctrl.useImm = 1'b1;
            imm         = {27'd0, shamt};
          end
          FN_JR: begin
            ctrl.jr       = 1'b1;
            ctrl.regWrite = 1'b0;
            dest          = '0;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        aluOp         = (op == OP_ADDI) ? ALU_ADD : ALU_SLT;
        ctrl.useImm   = 1'b1;
        ctrl.regWrite = 1'b1;
        imm           = signExt16(imm16);
        dest          = rt;
      end
      OP_ANDI, OP_ORI: begin
        aluOp         = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        ctrl.useImm   = 1'b1;
        ctrl.regWrite = 1'b1;
        imm           = {16'd0, imm16};
        dest          = rt;
      end
      OP_LUI: begin
        aluOp         = ALU_LUI;
        ctrl.useImm   = 1'b1;
        ctrl.regWrite = 1'b1;
        imm           = {imm16, 16'd0};
        dest          = rt;
      end
      OP_LW: begin
        ctrl.useImm   = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.memRead  = 1'b1;
        imm           = signExt16(imm16);
        dest          = rt;
      end
      OP_SW: begin
        ctrl.useImm   = 1'b1;
        ctrl.memWrite = 1'b1;
        imm           = signExt16(imm16);
        readsRt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        aluOp         = ALU_SUB;
        ctrl.branchEq = (op == OP_BEQ);
        ctrl.branchNe = (op == OP_BNE);
        imm           = signExt16(imm16);
        readsRt       = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump = 1'b1;
        isJal     = 1'b1;
        dest      = REG_RA;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl    = '0;
      dest    = '0;
      imm     = '0;
      readsRt = 1'b0;
    end
    // $zero is never written; jal's $ra goes through the register file's Jal port.
    if (dest == 5'd0 || isJal) ctrl.regWrite = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID latch, register-file addressing, ID/EX capture,
// load-use stall and flush handling.
module decode_stage
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  decode_stage_if.slave    fetch,
  output logic [4:0]       ReadReg1,
  output logic [4:0]       ReadReg2,
  input  logic [XLEN-1:0]  DataRead1,
  input  logic [XLEN-1:0]  DataRead2,
  output logic             Jal,
  output logic [31:0]      ImmiAddr,
  output logic             ExValid,
  output logic [3:0]       ExAluOp,
  output logic [XLEN-1:0]  ExA,
  output logic [XLEN-1:0]  ExB,
  output logic [XLEN-1:0]  ExImm,
  output logic [4:0]       ExDest,
  output logic [4:0]       ExRs,
  output logic [4:0]       ExRt,
  output logic             ExRegWrite,
  output logic             ExMemRead,
  output logic             ExMemWrite,
  output logic             ExBranchEq,
  output logic             ExBranchNe,
  output logic             ExJump,
  output logic             ExJr,
  output logic             ExUseImm,
  output logic [31:0]      ExTarget,
  output logic [31:0]      ExInstrAddr,
  output logic             Illegal
);

  logic        ifValid;
  logic [31:0] ifInstr;
  logic [31:0] ifAddr;

  ctrlT        decCtrl;
  aluOpT       decAluOp;
  logic [31:0] decImm;
  logic [4:0]  decDest;
  logic [4:0]  decRs;
  logic [4:0]  decRt;
  logic        decReadsRt;
  logic        decIsJal;
  logic        decIllegal;

  exRegT       exReg;
  exRegT       exNext;
  logic        hazard;
  logic        advance;

  instr_decoder uDecoder (
    .instr   (ifInstr),
    .ctrl    (decCtrl),
    .aluOp   (decAluOp),
    .imm     (decImm),
    .dest    (decDest),
    .rs      (decRs),
    .rt      (decRt),
    .readsRt (decReadsRt),
    .isJal   (decIsJal),
    .illegal (decIllegal)
  );

  assign hazard = ifValid && exReg.valid && exReg.ctrl.memRead && (exReg.dest != 5'd0) &&
                  ((exReg.dest == decRs) || (decReadsRt && (exReg.dest == decRt)));
  assign advance = ifValid && !hazard;

  assign fetch.InstrReady = !hazard;
  assign ReadReg1 = ifValid ? decRs : 5'd0;
  assign ReadReg2 = ifValid ? decRt : 5'd0;
  assign Jal      = advance && decIsJal && !fetch.Flush;
  assign ImmiAddr = ifValid ? ifAddr : 32'd0;

  // IF/ID: hold during a stall, drop everything on a redirect.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ifValid <= 1'b0;
      ifInstr <= '0;
      ifAddr  <= '0;
    end else if (fetch.Flush) begin
      ifValid <= 1'b0;
    end else if (!hazard) begin
      ifValid <= fetch.InstrValid;
      if (fetch.InstrValid) begin
        ifInstr <= fetch.Instr;
        ifAddr  <= fetch.InstrAddr;
      end
    end
  end

  // Next ID/EX contents; an empty or stalled IF/ID yields an all-zero bubble.
  always_comb begin
    exNext = '0;
    if (advance) begin
      exNext.valid     = 1'b1;
      exNext.aluOp     = decAluOp;
      exNext.ctrl      = decCtrl;
      exNext.a         = 32'(DataRead1);
      exNext.b         = 32'(DataRead2);
      exNext.imm       = decImm;
      exNext.dest      = decDest;
      exNext.rs        = decRs;
      exNext.rt        = decRt;
      exNext.target    = {ifAddr[31:26], ifInstr[25:0]};
      exNext.instrAddr = ifAddr;
    end
  end

  // ID/EX register; a redirect kills the instruction just leaving decode.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      exReg <= '0;
    end else if (fetch.Flush) begin
      exReg <= '0;
    end else begin
      exReg <= exNext;
    end
  end

  // Sticky flag for any unsupported encoding that reached ID/EX.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Illegal <= 1'b0;
    end else if (!fetch.Flush && advance && decIllegal) begin
      Illegal <= 1'b1;
    end
  end

  assign ExValid     = exReg.valid;
  assign ExAluOp     = exReg.aluOp;
  assign ExA         = XLEN'(exReg.a);
  assign ExB         = XLEN'(exReg.b);
  assign ExImm       = XLEN'(exReg.imm);
  assign ExDest      = exReg.dest;
  assign ExRs        = exReg.rs;
  assign ExRt        = exReg.rt;
  assign ExRegWrite  = exReg.ctrl.regWrite;
  assign ExMemRead   = exReg.ctrl.memRead;
  assign ExMemWrite  = exReg.ctrl.memWrite;
  assign ExBranchEq  = exReg.ctrl.branchEq;
  assign ExBranchNe  = exReg.ctrl.branchNe;
  assign ExJump      = exReg.ctrl.jump;
  assign ExJr        = exReg.ctrl.jr;
  assign ExUseImm    = exReg.ctrl.useImm;
  assign ExTarget    = exReg.target;
  assign ExInstrAddr = exReg.instrAddr;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction stream, expected
// ID/EX records queued at issue, popped by a monitor on each valid output.
module tb_decode_stage;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] DataRead1, DataRead2;
  logic        Jal;
  logic [31:0] ImmiAddr;
  logic        ExValid;
  logic [3:0]  ExAluOp;
  logic [31:0] ExA, ExB, ExImm;
  logic [4:0]  ExDest, ExRs, ExRt;
  logic        ExRegWrite, ExMemRead, ExMemWrite, ExBranchEq, ExBranchNe;
  logic        ExJump, ExJr, ExUseImm;
  logic [31:0] ExTarget, ExInstrAddr;
  logic        Illegal;

  decode_stage_if fif ();

  decode_stage #(.XLEN(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .fetch(fif),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .DataRead1(DataRead1), .DataRead2(DataRead2),
    .Jal(Jal), .ImmiAddr(ImmiAddr),
    .ExValid(ExValid), .ExAluOp(ExAluOp), .ExA(ExA), .ExB(ExB), .ExImm(ExImm),
    .ExDest(ExDest), .ExRs(ExRs), .ExRt(ExRt),
    .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite),
    .ExBranchEq(ExBranchEq), .ExBranchNe(ExBranchNe), .ExJump(ExJump),
    .ExJr(ExJr), .ExUseImm(ExUseImm), .ExTarget(ExTarget),
    .ExInstrAddr(ExInstrAddr), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  // Register file stand-in: register n reads as 0x1000 + n.
  assign DataRead1 = 32'h1000 + {27'd0, ReadReg1};
  assign DataRead2 = 32'h1000 + {27'd0, ReadReg2};

  localparam logic [31:0] ADDI1   = 32'h20010005; // addi $1,$0,5
  localparam logic [31:0] ADD2    = 32'h00211020; // add $2,$1,$1
  localparam logic [31:0] LW3     = 32'h8C230000; // lw $3,0($1)
  localparam logic [31:0] ADD4DEP = 32'h00622020; // add $4,$3,$2
  localparam logic [31:0] ADD4ND  = 32'h00052020; // add $4,$0,$5
  localparam logic [31:0] LW0     = 32'h8C200000; // lw $0,0($1)
  localparam logic [31:0] ADD6    = 32'h00003020; // add $6,$0,$0
  localparam logic [31:0] JAL40   = 32'h0C000040; // jal 0x40
  localparam logic [31:0] LW7     = 32'h8C270000; // lw $7,0($1)
  localparam logic [31:0] JALRS7  = 32'h0CE00000; // jal with rs field = 7
  localparam logic [31:0] BADOP   = 32'hFC000000; // opcode 0x3F

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  ctrl;   // {RegWrite,MemRead,MemWrite,BEq,BNe,Jump,Jr,UseImm}
    logic [4:0]  dest, rs, rt;
    logic [3:0]  alu;
    logic [31:0] a, b, imm, target;
    bit          chkAlu, chkImm, chkData;
  } expT;

  expT sb[$];
  expT e;
  int  asserts = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expPush(input logic [31:0] addr, input logic [7:0] ctrl,
                         input logic [4:0] dest, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] target,
                         input bit chkAlu, input bit chkImm, input bit chkData);
    expT x;
    x.addr = addr; x.ctrl = ctrl; x.dest = dest; x.rs = rs; x.rt = rt; x.alu = alu;
    x.a = a; x.b = b; x.imm = imm; x.target = target;
    x.chkAlu = chkAlu; x.chkImm = chkImm; x.chkData = chkData;
    sb.push_back(x);
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] adr, input bit fl);
    @(negedge Clk);
    fif.InstrValid = v;
    fif.Instr      = ins;
    fif.InstrAddr  = adr;
    fif.Flush      = fl;
    #1;
  endtask

  // Monitor: every live ID/EX output is matched against the oldest expectation.
  always @(negedge Clk) begin
    if (Rst_n && ExValid) begin
      if (sb.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL unexpected_ex: got ExInstrAddr 0x%08h, expected no instruction", ExInstrAddr);
      end else begin
        e = sb.pop_front();
        chk("ex_addr", ExInstrAddr, e.addr);
        chk("ex_ctrl", 32'({ExRegWrite, ExMemRead, ExMemWrite, ExBranchEq, ExBranchNe,
                            ExJump, ExJr, ExUseImm}), 32'(e.ctrl));
        chk("ex_dest", 32'(ExDest), 32'(e.dest));
        if (e.chkAlu) chk("ex_aluop", 32'(ExAluOp), 32'(e.alu));
        if (e.chkImm) chk("ex_imm", ExImm, e.imm);
        if (e.chkData) begin
          chk("ex_a", ExA, e.a);
          chk("ex_b", ExB, e.b);
          chk("ex_rs", 32'(ExRs), 32'(e.rs));
          chk("ex_rt", 32'(ExRt), 32'(e.rt));
          chk("ex_target", ExTarget, e.target);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    fif.InstrValid = 1'b0;
    fif.Instr      = '0;
    fif.InstrAddr  = '0;
    fif.Flush      = 1'b0;
    #2;
    chk("rst_ready", 32'(fif.InstrReady), 32'd1);
    chk("rst_exvalid", 32'(ExValid), 32'd0);
    chk("rst_illegal", 32'(Illegal), 32'd0);
    chk("rst_jal", 32'(Jal), 32'd0);
    chk("rst_immiaddr", ImmiAddr, 32'd0);
    chk("rst_readreg1", 32'(ReadReg1), 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Back-to-back ALU stream
    cyc(1, ADDI1, 32'd0, 0);
    chk("rdy_addi", 32'(fif.InstrReady), 32'd1);
    expPush(32'd0, 8'b1000_0001, 5'd1, 5'd0, 5'd1, 4'd0, 32'h1000, 32'h1001, 32'd5, 32'h00010005, 1, 1, 1);
    cyc(1, ADD2, 32'd1, 0);
    chk("rdy_add2", 32'(fif.InstrReady), 32'd1);
    expPush(32'd1, 8'b1000_0000, 5'd2, 5'd1, 5'd1, 4'd0, 32'h1001, 32'h1001, 32'd0, 32'h00211020, 1, 0, 1);

    // Load-use on $3
    cyc(1, LW3, 32'd2, 0);
    chk("rdy_lw3", 32'(fif.InstrReady), 32'd1);
    expPush(32'd2, 8'b1100_0001, 5'd3, 5'd1, 5'd3, 4'd0, 32'h1001, 32'h1003, 32'd0, 32'h00230000, 1, 1, 1);
    cyc(1, ADD4DEP, 32'd3, 0);
    chk("rdy_add4dep", 32'(fif.InstrReady), 32'd1);
    expPush(32'd3, 8'b1000_0000, 5'd4, 5'd3, 5'd2, 4'd0, 32'h1003, 32'h1002, 32'd0, 32'h00622020, 1, 0, 1);
    cyc(0, 32'd0, 32'd0, 0);
    chk("stall_ready", 32'(fif.InstrReady), 32'd0);
    cyc(0, 32'd0, 32'd0, 0);
    chk("stall_bubble_valid", 32'(ExValid), 32'd0);
    chk("stall_bubble_memread", 32'(ExMemRead), 32'd0);
    chk("stall_release_ready", 32'(fif.InstrReady), 32'd1);

    // No dependency, and a load into $0
    cyc(1, LW3, 32'd4, 0);
    expPush(32'd4, 8'b1100_0001, 5'd3, 5'd1, 5'd3, 4'd0, 32'h1001, 32'h1003, 32'd0, 32'h00230000, 1, 1, 1);
    cyc(1, ADD4ND, 32'd5, 0);
    expPush(32'd5, 8'b1000_0000, 5'd4, 5'd0, 5'd5, 4'd0, 32'h1000, 32'h1005, 32'd0, 32'h00052020, 1, 0, 1);
    cyc(1, LW0, 32'd6, 0);
    chk("nodep_ready", 32'(fif.InstrReady), 32'd1);
    expPush(32'd6, 8'b0100_0001, 5'd0, 5'd1, 5'd0, 4'd0, 32'h1001, 32'h1000, 32'd0, 32'h00200000, 1, 1, 1);
    cyc(1, ADD6, 32'd7, 0);
    expPush(32'd7, 8'b1000_0000, 5'd6, 5'd0, 5'd0, 4'd0, 32'h1000, 32'h1000, 32'd0, 32'h00003020, 1, 0, 1);
    cyc(1, JAL40, 32'h10, 0);
    chk("lw0_nostall_ready", 32'(fif.InstrReady), 32'd1);
    expPush(32'h10, 8'b0000_0100, 5'd31, 5'd0, 5'd0, 4'd0, 32'h1000, 32'h1000, 32'd0, 32'h00000040, 0, 0, 1);

    // jal strobe
    cyc(0, 32'd0, 32'd0, 0);
    chk("jal_pulse", 32'(Jal), 32'd1);
    chk("jal_immiaddr", ImmiAddr, 32'h10);
    cyc(0, 32'd0, 32'd0, 0);
    chk("jal_pulse_end", 32'(Jal), 32'd0);

    // Flush while jal sits in IF/ID behind a pending load-use stall
    cyc(1, LW7, 32'h18, 0);
    expPush(32'h18, 8'b1100_0001, 5'd7, 5'd1, 5'd7, 4'd0, 32'h1001, 32'h1007, 32'd0, 32'h00270000, 1, 1, 1);
    cyc(1, JALRS7, 32'h20, 0);
    cyc(1, ADD2, 32'h21, 1);
    chk("flush_jal", 32'(Jal), 32'd0);
    cyc(0, 32'd0, 32'd0, 0);
    chk("flush_exvalid", 32'(ExValid), 32'd0);
    chk("flush_ready", 32'(fif.InstrReady), 32'd1);
    chk("flush_ifid_empty", 32'(ReadReg1), 32'd0);
    chk("flush_immiaddr", ImmiAddr, 32'd0);
    cyc(0, 32'd0, 32'd0, 0);
    chk("flush_no_retry", 32'(ExValid), 32'd0);

    // Sticky illegal
    cyc(1, BADOP, 32'h30, 0);
    chk("illegal_before", 32'(Illegal), 32'd0);
    expPush(32'h30, 8'b0000_0000, 5'd0, 5'd0, 5'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0);
    cyc(1, ADDI1, 32'h31, 0);
    chk("illegal_in_ifid", 32'(Illegal), 32'd0);
    expPush(32'h31, 8'b1000_0001, 5'd1, 5'd0, 5'd1, 4'd0, 32'h1000, 32'h1001, 32'd5, 32'h00010005, 1, 1, 1);
    cyc(0, 32'd0, 32'd0, 0);
    chk("illegal_set", 32'(Illegal), 32'd1);
    cyc(0, 32'd0, 32'd0, 0);
    chk("illegal_sticky", 32'(Illegal), 32'd1);

    // Asynchronous reset in the middle of a stall
    cyc(1, LW3, 32'h40, 0);
    expPush(32'h40, 8'b1100_0001, 5'd3, 5'd1, 5'd3, 4'd0, 32'h1001, 32'h1003, 32'd0, 32'h00230000, 1, 1, 1);
    cyc(1, ADD4DEP, 32'h41, 0);
    cyc(0, 32'd0, 32'd0, 0);
    chk("rst_stall_ready", 32'(fif.InstrReady), 32'd0);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midrst_exvalid", 32'(ExValid), 32'd0);
    chk("midrst_ready", 32'(fif.InstrReady), 32'd1);
    chk("midrst_illegal", 32'(Illegal), 32'd0);
    chk("midrst_jal", 32'(Jal), 32'd0);
    chk("midrst_readreg1", 32'(ReadReg1), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Flush kills a jal that would otherwise strobe
    cyc(1, JAL40, 32'h50, 0);
    cyc(0, 32'd0, 32'd0, 1);
    chk("flush_jal_nohazard", 32'(Jal), 32'd0);
    cyc(0, 32'd0, 32'd0, 0);
    chk("flush2_exvalid", 32'(ExValid), 32'd0);
    chk("flush2_immiaddr", ImmiAddr, 32'd0);

    cyc(0, 32'd0, 32'd0, 0);
    cyc(0, 32'd0, 32'd0, 0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the 32-bit MIPS pipeline, directly upstream of the register file: it latches fetched instructions (IF/ID), drives the register file read addresses and `Jal`/`ImmiAddr` inputs, captures the returned operands with decoded controls into the ID/EX pipeline register, and stalls one cycle on load-use hazards. Word addressing is used throughout: `$ra` = `InstrAddr + 1`.

## Interface
Parameters:
- `XLEN`, 32: datapath width.

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Rst_n`  in  1  reset; asynchronous, active-low.
- `InstrValid`  in  1  fetch presents an instruction.
- `Instr`  in  32  instruction word.
- `InstrAddr`  in  32  word address of `Instr`.
- `InstrReady`  out  1  stage accepts `Instr` this cycle.
- `Flush`  in  1  branch/jump redirect; kill IF/ID and ID/EX contents.
- `ReadReg1`, `ReadReg2`  out  5  register file read addresses (rs, rt of the IF/ID instruction).
- `DataRead1`, `DataRead2`  in  32  register file read data.
- `Jal`  out  1  register file `$ra` write strobe.
- `ImmiAddr`  out  32  address of the jal instruction.
- `ExValid`  out  1  ID/EX holds a live instruction.
- `ExAluOp`  out  4  ALU operation code.
- `ExA`, `ExB`  out  32  captured rs/rt operands.
- `ExImm`  out  32  extended immediate (or shamt).
- `ExDest`  out  5  destination register.
- `ExRs`, `ExRt`  out  5  source indices for forwarding.
- `ExRegWrite`, `ExMemRead`, `ExMemWrite`, `ExBranchEq`, `ExBranchNe`, `ExJump`, `ExJr`, `ExUseImm`  out  1 each  controls.
- `ExTarget`  out  32  {`InstrAddr[31:26]`, `Instr[25:0]`} for j/jal.
- `ExInstrAddr`  out  32  address of the ID/EX instruction.
- `Illegal`  out  1  sticky: an unsupported opcode/funct was decoded.

## Operation
- Supported: R-type add, sub, and, or, slt, sll, srl, jr; addi, slti (sign-extended imm), andi, ori (zero-extended), lui (imm<<16); lw, sw, beq, bne, j, jal.
- Unsupported encoding: advances as a bubble-equivalent (all write/mem/branch controls 0, `ExValid`=1), sets `Illegal`; cleared only by reset.
- `ExDest`: rd for R-type, rt for I-type, 31 for jal, 0 for sw/branches/j/jr. `ExRegWrite`=0 when `ExDest`=0 or for jal (register file writes `$ra` via `Jal`).
- `ReadReg1/2` are combinational from IF/ID `Instr[25:21]`/`[20:16]`; zero when IF/ID is empty.
- Load-use hazard: IF/ID valid, `ExValid && ExMemRead && ExDest!=0`, and `ExDest` equals rs, or equals rt when the instruction reads rt (R-type, sw, beq, bne). Then: `InstrReady`=0, IF/ID holds, ID/EX loads a bubble (`ExValid`=0, all controls 0).
- `InstrReady` = !hazard. IF/ID loads `Instr` when `InstrValid && InstrReady`, else becomes empty when it advances.
- `Jal` = IF/ID holds jal, is advancing (no hazard), and `Flush`=0; `ImmiAddr` = IF/ID `InstrAddr` (0 when empty).
- `Flush` overrides everything: at the next edge IF/ID and ID/EX become empty; incoming instruction dropped; `Jal` suppressed that cycle; `InstrReady` is don't-care.
- No WB->ID forwarding here; downstream forwarding uses `ExRs`/`ExRt`.

## Timing
- Reset: all outputs 0, IF/ID and ID/EX empty, `Illegal`=0; `InstrReady`=1 during and after reset.
- Latency: instruction accepted at edge k appears on `Ex*` after edge k+1; throughput one per cycle absent hazards.
- Hazard stall exactly one cycle: the bubble clears `ExMemRead`, so the hazard condition drops.
- Reset asserted mid-stall or mid-flush: state clears immediately and asynchronously; no `Jal` pulse.
- Simultaneous `Flush` and hazard: flush wins, and no bubble-then-retry occurs.

## Structure
- Shared `mips_pkg`: opcode/funct constants, ALU op encodings (4-bit), register index 31 constant.
- One combinational sub-module `instr_decoder` (Instr -> controls, dest, immediate, illegal, reads-rt); `decode_stage` holds IF/ID, ID/EX, hazard and flush logic.

## Test plan
- Reset, then stream addi $1,$0,5 / add $2,$1,$1 -> `ExImm`=5, `ExDest`=1; next cycle `ExDest`=2, `ExRs`=`ExRt`=1, `InstrReady` stays 1.
- lw $3,0($1) followed by add $4,$3,$2 -> one cycle with `InstrReady`=0 and `ExValid`=0; add then appears with `ExA`=`DataRead1` of $3.
- lw $3 followed by add $4,$0,$5 (no dependency); lw $0 then add using $0 -> no stall in either case.
- jal target 0x40 at `InstrAddr` 0x10 -> `Jal`=1 for one cycle, `ImmiAddr`=0x10, `ExJump`=1, `ExTarget`=0x40, `ExRegWrite`=0.
- `Flush` asserted while jal is in IF/ID and a load-use stall is pending -> `Jal`=0; next cycle `ExValid`=0, IF/ID empty, `InstrReady`=1.
- Opcode 0x3F -> `Illegal` rises and stays 1 through later legal instructions until `Rst_n` low.
